mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between NREQ bus masters.
- Port 0 is the cpu load/store/stack path; port 1 is the program loader / DMA.
- Performs round-robin arbitration with an optional lock for multi-access sequences (cal/ret, psh/pop pairs).
- Sequences each granted access onto the RAM port and routes read data back to the winning requester.

Parameters:
- NREQ, 2, number of requesters (>=1).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  single clock, rising edge.
- async_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held stable until req_ack.
- req_write  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep grant for this requester's next request.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ack  out  NREQ  one-cycle pulse: command accepted.
- rsp_valid  out  NREQ  one-cycle pulse: rsp_rdata valid for requester i (reads only).
- rsp_rdata  out  DW  read data, shared by all requesters.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, state = ArbIdle, prio_ptr = 0, lock_owner invalid.
- FSM states: ArbIdle, ArbAccess, ArbReadWait.
- ArbIdle:
  - If lock is held and the lock owner has req_valid=1, the winner is the lock owner.
  - Otherwise the winner is the first set req_valid bit scanning from prio_ptr upward, wrapping at NREQ-1 to 0.
  - No valid requests: stay in ArbIdle, mem_en=0.
  - On a winner w, at the edge: req_ack[w]<=1, mem_en<=1, mem_we<=req_write[w], mem_addr/mem_wdata<=slice w, prio_ptr<=(w+1) mod NREQ, lock_owner<=w if req_lock[w] else invalid, go to ArbAccess.
- ArbAccess (RAM samples the command at the end of this cycle):
  - req_ack<=0 and mem_en<=0 at the edge.
  - Write: go to ArbIdle.
  - Read: go to ArbReadWait.
- ArbReadWait: rsp_rdata<=mem_rdata, rsp_valid[w]<=1, go to ArbIdle. rsp_valid clears the next cycle.
- Latency, counting from the cycle req_valid is first seen in ArbIdle as cycle 0:
  - req_ack is high in cycle 1.
  - Write is committed at the end of cycle 1.
  - Read: rsp_valid is high in cycle 3.
  - Back-to-back throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Requester rules:
  - A requester may drop or change req_valid, addr or data in the cycle after its ack.
  - Deasserting req_valid before ack is allowed; the request is simply not issued.
  - The arbiter samples only in ArbIdle. Requests arriving in other states wait.
- Lock:
  - Takes precedence over round-robin only while the owner is requesting in ArbIdle.
  - If the owner is idle in ArbIdle, the lock is released and round-robin resumes from prio_ptr.
- Simultaneous requests from all ports with no lock: strict rotation; starvation-free, max wait (NREQ-1) accesses.
- Address and data pass through unmodified; no wrap-around arithmetic on addresses.
- Reset asserted mid-operation: the in-flight access is abandoned. mem_en, req_ack and rsp_valid drop immediately (asynchronously). No late rsp_valid is ever issued.
- NREQ=1: degenerates to a pass-through sequencer with the same timing.

Decomposition:
- Package arb_pkg:
  - typedef enum ArbState {ArbIdle, ArbAccess, ArbReadWait}.
  - Default AW/DW localparams.
  - Function clog2-safe index width for NREQ (minimum 1).
- Sub-module rr_picker: combinational round-robin priority select.
  - Inputs: valid[NREQ], ptr.
  - Outputs: found, idx.
  - Reused later by the io arbiter.

Test Plan:
- Single read, port 0, addr 16'h0010, RAM preloaded 16'hBEEF:
  - req_ack[0] in cycle 1; mem_en=1, mem_we=0, mem_addr=16'h0010 in cycle 1.
  - rsp_valid[0]=1 with rsp_rdata=16'hBEEF in cycle 3.
  - rsp_valid[1] stays 0.
- Single write, port 1, addr 16'hFFFF, data 16'h1234:
  - ack in cycle 1; mem_we=1, mem_wdata=16'h1234 in cycle 1.
  - No rsp_valid.
  - A following port 0 read of 16'hFFFF returns 16'h1234.
- Both ports request writes continuously from reset:
  - Grants alternate 0,1,0,1 on consecutive acks, each 2 cycles apart.
  - RAM log matches the issue order.
- Port 0 issues 3 reads with req_lock=1 while port 1 requests continuously:
  - Port 0 gets 3 consecutive grants; port 1 is granted on the next arbitration.
  - Port 0 then drops valid for one ArbIdle cycle: the lock is released and port 1 wins.
- async_rst pulsed during ArbReadWait of a port 0 read:
  - All outputs are 0 immediately; rsp_valid[0] never asserts.
  - After release, a new port 1 request wins first (prio_ptr=0 but port 0 idle), ack in cycle 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory arbiter and related arbiters.
package arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAccess,
    ArbReadWait
  } arb_state_e;

  localparam int unsigned DefaultAw = 16;
  localparam int unsigned DefaultDw = 16;

  // Index width for n requesters; never below 1 so NREQ=1 still gets a real vector.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side bus of the memory arbiter.
interface mem_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = DefaultAw,
  parameter int unsigned DW   = DefaultDw
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  // Requesters plus RAM model side.
  modport master (
    output req_valid, req_write, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ack, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ack, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set valid bit at or above ptr, wrapping.
module rr_picker
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   tmp;
  int unsigned       k;

  // Rotate so ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {valid, valid};
    rot   = NREQ'(dbl >> ptr);
    found = 1'b0;
    idx   = '0;
    tmp   = '0;
    k     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      tmp = rot >> i;
      if (!found && tmp[0]) begin
        found = 1'b1;
        k     = 32'(ptr) + i;
        if (k >= NREQ) k = k - NREQ;
        idx = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with lock sharing one single-port synchronous RAM.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = DefaultAw,
  parameter int unsigned DW   = DefaultDw
) (
  input logic          clk,
  input logic          async_rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_w(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   prio_ptr_q, prio_ptr_d;
  logic [IW-1:0]   lock_owner_q, lock_owner_d;
  logic            lock_valid_q, lock_valid_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            owner_req;
  logic            win_valid;
  logic [IW-1:0]   win;
  int unsigned     nxt;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .valid (bus.req_valid),
    .ptr   (prio_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state: arbitrate in idle, then sequence the access onto the RAM port.
  always_comb begin
    state_d      = state_q;
    prio_ptr_d   = prio_ptr_q;
    lock_owner_d = lock_owner_q;
    lock_valid_d = lock_valid_q;
    cur_d        = cur_q;
    req_ack_d    = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    owner_req    = lock_valid_q & bus.req_valid[lock_owner_q];
    win_valid    = 1'b0;
    win          = '0;
    nxt          = 0;

    case (state_q)
      ArbIdle: begin
        if (owner_req) begin
          win       = lock_owner_q;
          win_valid = 1'b1;
        end else begin
          // An idle owner forfeits the lock; round-robin resumes from prio_ptr.
          lock_valid_d = 1'b0;
          win          = pick_idx;
          win_valid    = pick_found;
        end
        if (win_valid) begin
          req_ack_d    = NREQ'(1) << win;
          mem_en_d     = 1'b1;
          mem_we_d     = bus.req_write[win];
          mem_addr_d   = AW'(bus.req_addr >> (32'(win) * AW));
          mem_wdata_d  = DW'(bus.req_wdata >> (32'(win) * DW));
          nxt          = 32'(win) + 1;
          if (nxt >= NREQ) nxt = 0;
          prio_ptr_d   = nxt[IW-1:0];
          lock_valid_d = bus.req_lock[win];
          lock_owner_d = win;
          cur_d        = win;
          state_d      = ArbAccess;
        end
      end
      ArbAccess: begin
        state_d = mem_we_q ? ArbIdle : ArbReadWait;
      end
      ArbReadWait: begin
        rsp_rdata_d = bus.mem_rdata;
        rsp_valid_d = NREQ'(1) << cur_q;
        state_d     = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q      <= ArbIdle;
      prio_ptr_q   <= '0;
      lock_owner_q <= '0;
      lock_valid_q <= 1'b0;
      cur_q        <= '0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      prio_ptr_q   <= prio_ptr_d;
      lock_owner_q <= lock_owner_d;
      lock_valid_q <= lock_valid_d;
      cur_q        <= cur_d;
      req_ack_q    <= req_ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ack   = req_ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and requester model.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int          NTX  = 24;

  logic clk = 1'b0;
  logic async_rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus)
  );

  // Behavioural RAM with a backdoor preload port.
  logic [DW-1:0] ram [0:65535];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] pool   [8];
  logic [DW-1:0] shadow [8];
  logic          tx_we  [2][NTX];
  int            tx_ai  [2][NTX];
  logic [DW-1:0] tx_d   [2][NTX];

  task automatic set_req(input int p, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[p]          = 1'b1;
    bus.req_write[p]          = w;
    bus.req_lock[p]           = l;
    bus.req_addr[p*AW +: AW]  = a;
    bus.req_wdata[p*DW +: DW] = d;
  endtask

  task automatic clr_req(input int p);
    bus.req_valid[p] = 1'b0;
    bus.req_write[p] = 1'b0;
    bus.req_lock[p]  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    async_rst = 1'b1;
    clr_req(0);
    clr_req(1);
    @(negedge clk);
    @(negedge clk);
    async_rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    async_rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", bus.req_ack); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_rdata !== 16'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", bus.rsp_rdata); end
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0000", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata !== 16'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h want 0000", bus.mem_wdata); end
    @(negedge clk);
    async_rst = 1'b0;
  endtask

  task automatic test_single_read();
    preload(16'h0010, 16'hBEEF);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus.req_ack !== 2'b01) begin n_err++; $display("FAIL rd_ack: got %b want 01", bus.req_ack); end
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL rd_mem_en: got %b want 1", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rd_mem_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL rd_mem_addr: got %h want 0010", bus.mem_addr); end
        clr_req(0);
      end
      if (c == 2) begin
        n_cmp++; if (bus.req_ack !== 2'b00) begin n_err++; $display("FAIL rd_ack_pulse: got %b want 00", bus.req_ack); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL rd_mem_en_pulse: got %b want 0", bus.mem_en); end
      end
      if (c == 3) begin
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want beef", bus.rsp_rdata); end
      end
      if (c == 4) begin
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_rsp_clear: got %b want 00", bus.rsp_valid); end
      end
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 16'hFFFF, 16'h1234);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus.req_ack !== 2'b10) begin n_err++; $display("FAIL wr_ack: got %b want 10", bus.req_ack); end
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_err++; $display("FAIL wr_mem_en: got %b want 1", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wr_mem_addr: got %h want ffff", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 16'h1234) begin n_err++; $display("FAIL wr_mem_wdata: got %h want 1234", bus.mem_wdata); end
        clr_req(1);
      end else begin
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_no_rsp: got %b want 00 (cycle %0d)", bus.rsp_valid, c); end
      end
    end
    n_cmp++; if (ram[16'hFFFF] !== 16'h1234) begin n_err++; $display("FAIL wr_ram: got %h want 1234", ram[16'hFFFF]); end
    set_req(0, 1'b0, 1'b0, 16'hFFFF, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus.req_ack !== 2'b01) begin n_err++; $display("FAIL wr_rb_ack: got %b want 01", bus.req_ack); end
        clr_req(0);
      end
      if (c == 3) begin
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL wr_rb_valid: got %b want 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 16'h1234) begin n_err++; $display("FAIL wr_rb_rdata: got %h want 1234", bus.rsp_rdata); end
      end
    end
  endtask

  task automatic test_alternating_writes();
    logic [AW-1:0] wa [2][8];
    logic [DW-1:0] wd [2][8];
    int idx [2];
    int cyc, last, got, exp_p, pa;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      idx[p] = 0;
      for (int i = 0; i < 8; i++) begin
        wa[p][i] = 16'(16'h2000 + p * 16'h100 + i);
        wd[p][i] = 16'($urandom);
      end
    end
    cyc = 0; last = -1; got = 0; exp_p = 0;
    set_req(0, 1'b1, 1'b0, wa[0][0], wd[0][0]);
    set_req(1, 1'b1, 1'b0, wa[1][0], wd[1][0]);
    while (got < 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ack != 2'b00) begin
        pa = bus.req_ack[1] ? 1 : 0;
        n_cmp++; if (bus.req_ack !== (2'b01 << exp_p)) begin n_err++; $display("FAIL alt_grant: got %b want %b (ack #%0d)", bus.req_ack, 2'b01 << exp_p, got); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != 2) begin n_err++; $display("FAIL alt_gap: got %0d want 2", cyc - last); end
        end
        n_cmp++; if (bus.mem_addr !== wa[exp_p][idx[exp_p]]) begin n_err++; $display("FAIL alt_addr: got %h want %h", bus.mem_addr, wa[exp_p][idx[exp_p]]); end
        n_cmp++; if (bus.mem_wdata !== wd[exp_p][idx[exp_p]]) begin n_err++; $display("FAIL alt_wdata: got %h want %h", bus.mem_wdata, wd[exp_p][idx[exp_p]]); end
        idx[pa]++;
        if (idx[pa] < 8) set_req(pa, 1'b1, 1'b0, wa[pa][idx[pa]], wd[pa][idx[pa]]);
        else clr_req(pa);
        last = cyc;
        got++;
        exp_p = 1 - exp_p;
      end
    end
    n_cmp++; if (got != 16) begin n_err++; $display("FAIL alt_timeout: got %0d acks want 16", got); end
    clr_req(0);
    clr_req(1);
    @(negedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (ram[wa[p][i]] !== wd[p][i]) begin n_err++; $display("FAIL alt_ram: addr %h got %h want %h", wa[p][i], ram[wa[p][i]], wd[p][i]); end
      end
    end
  endtask

  task automatic test_lock();
    int exp_seq [6];
    int cyc, got, pa, p0_done, p1_done;
    exp_seq = '{0, 0, 0, 1, 0, 1};
    do_reset();
    cyc = 0; got = 0; p0_done = 0; p1_done = 0;
    set_req(0, 1'b0, 1'b1, 16'h4000, 16'h0);
    set_req(1, 1'b1, 1'b0, 16'h3000, 16'($urandom));
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.req_ack != 2'b00) begin
        pa = bus.req_ack[1] ? 1 : 0;
        n_cmp++; if (bus.req_ack !== (2'b01 << exp_seq[got])) begin n_err++; $display("FAIL lock_grant: got %b want %b (ack #%0d)", bus.req_ack, 2'b01 << exp_seq[got], got); end
        got++;
        if (pa == 0) begin
          p0_done++;
          if (p0_done < 3) set_req(0, 1'b0, 1'b1, 16'(16'h4000 + p0_done), 16'h0);
          else clr_req(0);
        end else begin
          p1_done++;
          set_req(1, 1'b1, 1'b0, 16'(16'h3000 + p1_done), 16'($urandom));
          // Port 0 returns unlocked; round-robin must now pick it first.
          if (p1_done == 1) set_req(0, 1'b0, 1'b0, 16'h4010, 16'h0);
        end
      end
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL lock_timeout: got %0d acks want 6", got); end
    clr_req(0);
    clr_req(1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    n_cmp++; if (bus.req_ack !== 2'b01) begin n_err++; $display("FAIL mr_ack: got %b want 01", bus.req_ack); end
    clr_req(0);
    @(negedge clk);
    async_rst = 1'b1;
    #1;
    n_cmp++; if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL mr_mem_en: got %b want 0", bus.mem_en); end
    n_cmp++; if (bus.req_ack !== 2'b00) begin n_err++; $display("FAIL mr_ack_clr: got %b want 00", bus.req_ack); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL mr_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_cmp++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL mr_mem_addr: got %h want 0000", bus.mem_addr); end
    n_cmp++; if (bus.rsp_rdata !== 16'h0) begin n_err++; $display("FAIL mr_rdata: got %h want 0000", bus.rsp_rdata); end
    @(negedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL mr_late_rsp: got %b want 00", bus.rsp_valid); end
    end
    set_req(1, 1'b0, 1'b0, 16'h0010, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (bus.req_ack !== 2'b10) begin n_err++; $display("FAIL mr_p1_ack: got %b want 10", bus.req_ack); end
        clr_req(1);
      end
      if (c == 3) begin
        n_cmp++; if (bus.rsp_valid !== 2'b10) begin n_err++; $display("FAIL mr_p1_valid: got %b want 10", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL mr_p1_rdata: got %h want beef", bus.rsp_rdata); end
      end
    end
  endtask

  task automatic test_random();
    int idx [2];
    int cyc, last, got, exp_p, pa, ai, rsp_cyc, rsp_p;
    logic last_we, rsp_pend, we;
    logic [DW-1:0] rsp_d;
    logic [1:0] exp_rv;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pool[i]   = {8'(8'h50 + i), 8'($urandom)};
      shadow[i] = 16'($urandom);
      preload(pool[i], shadow[i]);
    end
    for (int p = 0; p < 2; p++) begin
      idx[p] = 0;
      for (int i = 0; i < NTX; i++) begin
        tx_we[p][i] = 1'($urandom_range(0, 1));
        tx_ai[p][i] = int'($urandom_range(0, 7));
        tx_d[p][i]  = 16'($urandom);
      end
    end
    cyc = 0; last = -1; got = 0; exp_p = 0; last_we = 1'b0;
    rsp_pend = 1'b0; rsp_cyc = 0; rsp_p = 0; rsp_d = '0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) set_req(p, tx_we[p][0], 1'b0, pool[tx_ai[p][0]], tx_d[p][0]);
    while ((got < 2 * NTX || rsp_pend) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      exp_rv = (rsp_pend && cyc == rsp_cyc) ? (2'b01 << rsp_p) : 2'b00;
      n_cmp++; if (bus.rsp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_rsp_valid: got %b want %b (cycle %0d)", bus.rsp_valid, exp_rv, cyc); end
      if (rsp_pend && cyc == rsp_cyc) begin
        n_cmp++; if (bus.rsp_rdata !== rsp_d) begin n_err++; $display("FAIL rnd_rdata: got %h want %h", bus.rsp_rdata, rsp_d); end
        rsp_pend = 1'b0;
      end
      if (bus.req_ack != 2'b00) begin
        pa = bus.req_ack[1] ? 1 : 0;
        we = tx_we[exp_p][idx[exp_p]];
        ai = tx_ai[exp_p][idx[exp_p]];
        n_cmp++; if (bus.req_ack !== (2'b01 << exp_p)) begin n_err++; $display("FAIL rnd_grant: got %b want %b", bus.req_ack, 2'b01 << exp_p); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != (last_we ? 2 : 3)) begin n_err++; $display("FAIL rnd_gap: got %0d want %0d", cyc - last, last_we ? 2 : 3); end
        end
        n_cmp++; if (bus.mem_we !== we) begin n_err++; $display("FAIL rnd_we: got %b want %b", bus.mem_we, we); end
        n_cmp++; if (bus.mem_addr !== pool[ai]) begin n_err++; $display("FAIL rnd_addr: got %h want %h", bus.mem_addr, pool[ai]); end
        if (we) begin
          n_cmp++; if (bus.mem_wdata !== tx_d[exp_p][idx[exp_p]]) begin n_err++; $display("FAIL rnd_wdata: got %h want %h", bus.mem_wdata, tx_d[exp_p][idx[exp_p]]); end
          shadow[ai] = tx_d[exp_p][idx[exp_p]];
        end else begin
          rsp_pend = 1'b1;
          rsp_cyc  = cyc + 2;
          rsp_p    = exp_p;
          rsp_d    = shadow[ai];
        end
        idx[pa]++;
        if (idx[pa] < NTX) set_req(pa, tx_we[pa][idx[pa]], 1'b0, pool[tx_ai[pa][idx[pa]]], tx_d[pa][idx[pa]]);
        else clr_req(pa);
        last    = cyc;
        last_we = we;
        got++;
        exp_p   = 1 - exp_p;
      end
    end
    n_cmp++; if (got != 2 * NTX || rsp_pend) begin n_err++; $display("FAIL rnd_timeout: got %0d acks want %0d", got, 2 * NTX); end
    clr_req(0);
    clr_req(1);
  endtask

  initial begin
    async_rst     = 1'b0;
    pl_en         = 1'b0;
    pl_addr       = '0;
    pl_data       = '0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #2 async_rst = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_alternating_writes();
    test_lock();
    test_reset_midread();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
